// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - single-stage add/sub/and/xor pipeline with valid/ready handshake
// Optional condition-code register enabled by defining ALU_PIPE_CC_EN.
module alu_pipe #(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result;
    logic             ovf;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign sum      = a + b;
    assign diff     = a - b;

    // Signed overflow from operand/result sign bits; logic ops never overflow.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unique case (ctrl)
            2'b00: begin
                result = sum;
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            2'b01: begin
                result = diff;
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            2'b10:   result = a & b;
            default: result = a ^ b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_ovf   <= ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_PIPE_CC_EN
    logic [2:0] cc;

    // Flags follow acceptance, not drain, so they lead out_valid by nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= CC_RESET;
        end else if (accept && set_cc) begin
            cc <= {result == '0, result[WIDTH-1], ovf};
        end
    end

    assign {cc_zf, cc_sf, cc_of} = cc;
`else
    localparam logic [2:0] unused_cc_reset = CC_RESET;
    logic unused_set_cc;

    assign unused_set_cc = set_cc ^ (|unused_cc_reset);
    assign cc_zf = 1'b0;
    assign cc_sf = 1'b0;
    assign cc_of = 1'b0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe (WIDTH=64 main instance, WIDTH=8 side instance)
module tb_alu_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, set_cc, out_valid, out_ready, out_ovf;
    logic [1:0]  ctrl;
    logic [63:0] a, b, out_data;
    logic        cc_zf, cc_sf, cc_of;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_ovf8, set_cc8;
    logic [1:0]  ctrl8;
    logic [7:0]  a8, b8, out_data8;
    logic        cc_zf8, cc_sf8, cc_of8;

`ifdef ALU_PIPE_CC_EN
    localparam logic [2:0] CC_RST = 3'b100;
`else
    localparam logic [2:0] CC_RST = 3'b000;
`endif

    int          n_total = 0;
    int          n_pass  = 0;
    logic [64:0] sb[$];
    logic        m_valid;
    logic [2:0]  exp_cc;
    logic        acc;

    alu_pipe #(.WIDTH(64), .CC_RESET(3'b100)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .a(a), .b(b), .set_cc(set_cc), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    alu_pipe #(.WIDTH(8), .CC_RESET(3'b100)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .ctrl(ctrl8), .a(a8), .b(b8), .set_cc(set_cc8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_data(out_data8), .out_ovf(out_ovf8),
        .cc_zf(cc_zf8), .cc_sf(cc_sf8), .cc_of(cc_of8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference: exact sum in 66 bits, overflow when it does not fit in 64 signed bits.
    function automatic logic [64:0] ref64(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y);
        logic [65:0] wide;
        logic        o;
        wide = '0;
        o    = 1'b0;
        case (c)
            2'd0: wide = {{2{x[63]}}, x} + {{2{y[63]}}, y};
            2'd1: wide = {{2{x[63]}}, x} - {{2{y[63]}}, y};
            2'd2: wide = {2'b00, x & y};
            default: wide = {2'b00, x ^ y};
        endcase
        if (c < 2'd2) o = !(wide[65:63] == 3'b000 || wide[65:63] == 3'b111);
        return {o, wide[63:0]};
    endfunction

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic cycle(input logic iv, input logic [1:0] c, input logic [63:0] x, input logic [63:0] y,
                         input logic sc, input logic ordy, output logic accepted);
        logic        exp_ready;
        logic [64:0] e;
        in_valid = iv; ctrl = c; a = x; b = y; set_cc = sc; out_ready = ordy;
        #1;
        exp_ready = !m_valid || ordy;
        check("in_ready", {127'd0, in_ready}, {127'd0, exp_ready});
        if (m_valid && ordy) void'(sb.pop_front());
        accepted = iv && exp_ready;
        if (accepted) begin
            e = ref64(c, x, y);
            sb.push_back(e);
`ifdef ALU_PIPE_CC_EN
            if (sc) exp_cc = {e[63:0] == 64'd0, e[63], e[64]};
`endif
        end
        m_valid = accepted || (m_valid && !ordy);
        @(posedge clk);
        #1;
        check("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
        if (m_valid) begin
            check("out_data", {64'd0, out_data}, {64'd0, sb[0][63:0]});
            check("out_ovf", {127'd0, out_ovf}, {127'd0, sb[0][64]});
        end
        check("cc", {125'd0, cc_zf, cc_sf, cc_of}, {125'd0, exp_cc});
        @(negedge clk);
    endtask

    task automatic op8(input logic [1:0] c, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] exp_d, input logic exp_o);
        in_valid8 = 1'b1; ctrl8 = c; a8 = x; b8 = y;
        @(posedge clk);
        #1;
        check("w8_valid", {127'd0, out_valid8}, 128'd1);
        check("w8_data", {120'd0, out_data8}, {120'd0, exp_d});
        check("w8_ovf", {127'd0, out_ovf8}, {127'd0, exp_o});
        check("w8_cc", {125'd0, cc_zf8, cc_sf8, cc_of8}, {125'd0, CC_RST});
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; ctrl = 2'd0; a = '0; b = '0; set_cc = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; ctrl8 = 2'd0; a8 = '0; b8 = '0; set_cc8 = 1'b0; out_ready8 = 1'b1;
        m_valid = 1'b0;
        exp_cc  = CC_RST;
        #3;
        check("rst_valid", {127'd0, out_valid}, 128'd0);
        check("rst_data", {64'd0, out_data}, 128'd0);
        check("rst_ovf", {127'd0, out_ovf}, 128'd0);
        check("rst_cc", {125'd0, cc_zf, cc_sf, cc_of}, {125'd0, CC_RST});
        @(negedge clk);
        rst_n = 1'b1;

        // Add overflow, first edge after reset.
        cycle(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1, acc);
        check("add_ovf_data", {64'd0, out_data}, {64'd0, 64'h8000_0000_0000_0000});
        check("add_ovf_flag", {127'd0, out_ovf}, 128'd1);
`ifdef ALU_PIPE_CC_EN
        check("add_ovf_cc", {125'd0, cc_zf, cc_sf, cc_of}, {125'd0, 3'b011});
`endif
        // Sub to zero, then sub without CC update.
        cycle(1'b1, 2'b01, 64'h1234, 64'h1234, 1'b1, 1'b1, acc);
        check("sub_zero_data", {64'd0, out_data}, 128'd0);
        cycle(1'b1, 2'b01, 64'd5, 64'd9, 1'b0, 1'b1, acc);
        check("sub_neg_data", {64'd0, out_data}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFC});
        cycle(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1, acc);

        // Backpressure: results must appear in order with nothing lost.
        cycle(1'b1, 2'b11, 64'hF0, 64'h0F, 1'b0, 1'b0, acc);
        cycle(1'b1, 2'b10, 64'hFF, 64'h0F, 1'b0, 1'b0, acc);
        cycle(1'b1, 2'b10, 64'hFF, 64'h0F, 1'b0, 1'b0, acc);
        check("held_data", {64'd0, out_data}, {64'd0, 64'hFF});
        cycle(1'b1, 2'b10, 64'hFF, 64'h0F, 1'b0, 1'b1, acc);
        check("bp_second", {64'd0, out_data}, {64'd0, 64'h0F});
        cycle(1'b1, 2'b00, 64'd2, 64'd3, 1'b1, 1'b1, acc);
        check("bp_third", {64'd0, out_data}, {64'd0, 64'd5});
        cycle(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1, acc);

        // Streaming at full rate.
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'b1, acc);
        end
        cycle(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1, acc);

        // Reset while a result is held.
        cycle(1'b1, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, acc);
        cycle(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, acc);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst_data", {64'd0, out_data}, 128'd0);
        check("mid_rst_cc", {125'd0, cc_zf, cc_sf, cc_of}, {125'd0, CC_RST});
        check("mid_rst_ready", {127'd0, in_ready}, 128'd1);
        #1 rst_n = 1'b1;
        sb.delete();
        m_valid = 1'b0;
        exp_cc  = CC_RST;
        @(negedge clk);
        cycle(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1, acc);
        cycle(1'b1, 2'b01, 64'd3, 64'd7, 1'b1, 1'b1, acc);
        cycle(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1, acc);

        // 8-bit instance boundary cases.
        op8(2'b01, 8'h80, 8'h01, 8'h7F, 1'b1);
        op8(2'b00, 8'h7F, 8'h01, 8'h80, 1'b1);
        op8(2'b01, 8'h10, 8'h20, 8'hF0, 1'b0);
        op8(2'b11, 8'hA5, 8'hFF, 8'h5A, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
